// File: rtl/ks_add_pkg.sv
// Shared types and helpers for the shared Kogge-Stone adder front-end.
package ks_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  // Number of en cycles the staged adder needs before its output is valid.
  function automatic int ks_lat(int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/ks_add_arbiter_if.sv
// Requester and response ports of the shared adder arbiter.
//
// Handshake rules: a requester transfer happens on a rising clk edge where
// req_valid[i] & req_ready[i]; a response transfer happens on a rising edge
// where rsp_valid & rsp_ready. A valid, once raised, keeps its payload
// stable until the transfer; ready never depends on the payload.
interface ks_add_arbiter_if #(
  parameter int N    = 64,
  parameter int NREQ = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [N-1:0]      rsp_data;
  logic [IDW-1:0]    rsp_id;
  logic              busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/ks_add.sv
// Staged Kogge-Stone adder. Every register level advances only while en is
// high, so with stable a/b the sum is valid after $clog2(N)+1 en cycles and
// then holds while en is low. Carry-out is not produced.
module ks_add #(
  parameter int N = 64
) (
  input  logic         clk,
  input  logic         rstn_,
  input  logic         en,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] out
);
  localparam int S = $clog2(N);

  // Generate/propagate are kept shifted up by one position: position i stands
  // for operand bit i-1 and position 0 is the (zero) carry-in. The prefix at
  // position i is then directly the carry into sum bit i.
  logic [N-1:0] h_q;
  logic [N-1:0] g_q [S+1];
  logic [N-1:0] g_d [S+1];
  logic [N-1:0] p_q [S];
  logic [N-1:0] p_d [S];

  assign g_d[0] = {a[N-2:0] & b[N-2:0], 1'b0};
  assign p_d[0] = {a[N-2:0] ^ b[N-2:0], 1'b0};

  for (genvar k = 1; k <= S; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    assign g_d[k] = g_q[k-1] | (p_q[k-1] & {g_q[k-1][N-1-D:0], {D{1'b0}}});
    if (k < S) begin : g_prop
      assign p_d[k] = p_q[k-1] & {p_q[k-1][N-1-D:0], {D{1'b1}}};
    end
  end

  // Advance every prefix level by one step per en cycle; clear on reset.
  always_ff @(posedge clk) begin
    if (!rstn_) begin
      h_q <= '0;
      for (int k = 0; k <= S; k++) g_q[k] <= '0;
      for (int k = 0; k < S; k++)  p_q[k] <= '0;
    end else if (en) begin
      h_q <= a ^ b;
      for (int k = 0; k <= S; k++) g_q[k] <= g_d[k];
      for (int k = 0; k < S; k++)  p_q[k] <= p_d[k];
    end
  end

  assign out = h_q ^ g_q[S];

endmodule

// File: rtl/ks_add_arbiter.sv
// Round-robin front-end that shares one staged ks_add between NREQ clients
// and returns each sum tagged with the issuing requester's index.
module ks_add_arbiter
  import ks_add_pkg::*;
#(
  parameter int N    = 64,
  parameter int NREQ = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  ks_add_arbiter_if.slave          bus,
  output arb_state_e               dbg_state,
  output logic [$clog2(NREQ)-1:0]  dbg_rr_ptr
);
  localparam int IDW = $clog2(NREQ);
  localparam int LAT = ks_lat(N);
  localparam int CW  = $clog2(LAT + 1);

  arb_state_e     state;
  logic [IDW-1:0] rr_ptr;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   op_a;
  logic [N-1:0]   op_b;
  logic [IDW-1:0] id_q;
  logic [N-1:0]   add_out;

  logic           grant_found;
  logic [IDW-1:0] grant_idx;
  logic [IDW:0]   cand;
  logic [NREQ-1:0] req_ready;

  // First valid requester at or above rr_ptr, wrapping modulo NREQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) cand = cand - (IDW+1)'(NREQ);
      if (!grant_found && bus.req_valid[cand[IDW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[IDW-1:0];
      end
    end
  end

  // One-hot accept, offered only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if (!rst && state == IDLE && grant_found) req_ready[grant_idx] = 1'b1;
  end

  // Control FSM: capture a grant, run the adder LAT cycles, hold the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      rr_ptr <= '0;
      cnt    <= '0;
      op_a   <= '0;
      op_b   <= '0;
      id_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            op_a   <= bus.req_a[grant_idx*N +: N];
            op_b   <= bus.req_b[grant_idx*N +: N];
            id_q   <= grant_idx;
            rr_ptr <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            cnt    <= '0;
            state  <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(LAT - 1)) state <= RSP;
        end
        RSP: begin
          if (bus.rsp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  ks_add #(.N(N)) u_add (
    .clk   (clk),
    .rstn_ (~rst),
    .en    (state == RUN),
    .a     (op_a),
    .b     (op_b),
    .out   (add_out)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = (state == RSP);
  assign bus.rsp_data  = add_out;
  assign bus.rsp_id    = id_q;
  assign bus.busy      = (state != IDLE);
  assign dbg_state     = state;
  assign dbg_rr_ptr    = rr_ptr;

endmodule

// File: tb/tb_ks_add_arbiter.sv
// Directed bench for the shared adder arbiter (N=64, NREQ=4).
module tb_ks_add_arbiter;
  import ks_add_pkg::*;

  localparam int N    = 64;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int LAT  = ks_lat(N);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ks_add_arbiter_if #(.N(N), .NREQ(NREQ)) bus();
  arb_state_e     dbg_state;
  logic [IDW-1:0] dbg_rr_ptr;

  ks_add_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_state  (dbg_state),
    .dbg_rr_ptr (dbg_rr_ptr)
  );

  // ---------------- scoreboard ----------------
  logic [N+IDW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_req(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    bus.req_valid[id]     = 1'b1;
    bus.req_a[id*N +: N]  = a;
    bus.req_b[id*N +: N]  = b;
  endtask

  task automatic clr_req(input int id);
    bus.req_valid[id] = 1'b0;
  endtask

  // Waits (bounded) for a negedge where some req_ready bit is set.
  task automatic wait_grant(input string tag, output int g);
    int k;
    g = -1;
    for (k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.req_ready != '0) break;
    end
    check({tag, "_gnt_seen"}, (k < 40), 1);
    for (int i = 0; i < NREQ; i++)
      if (bus.req_ready == NREQ'(1 << i)) g = i;
  endtask

  // Called just after the request handshake edge with n=1; counts edges until
  // rsp_valid is seen at a negedge.
  task automatic wait_rsp(input string tag, inout int n);
    while (n < 40) begin
      @(negedge clk);
      if (bus.rsp_valid) break;
      if (n == 1) begin
        check({tag, "_busy_run"}, bus.busy, 1);
        check({tag, "_rdy_run"}, bus.req_ready, 0);
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_rsp_seen"}, bus.rsp_valid, 1);
  endtask

  // At a negedge with rsp_valid: compare against the scoreboard and consume.
  task automatic take_rsp(input string tag);
    logic [N+IDW-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_sb_nonempty"}, 0, 1);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, bus.rsp_data, e[N-1:0]);
      check({tag, "_id"}, bus.rsp_id, e[N+IDW-1:N]);
    end
    @(posedge clk); #1;
  endtask

  task automatic issue(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] sum, input string tag);
    int g;
    int n;
    set_req(id, a, b);
    wait_grant(tag, g);
    check({tag, "_gnt"}, g, id);
    exp_q.push_back({IDW'(id), sum});
    @(posedge clk); #1;
    clr_req(id);
    n = 1;
    wait_rsp(tag, n);
    check({tag, "_lat"}, n, LAT + 1);
    take_rsp(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    int g;
    int n;
    int last_cyc;
    int order[5]           = '{0, 1, 2, 3, 0};
    logic [N-1:0] fsum[5]  = '{64'd11, 64'd22, 64'd33, 64'd44, 64'd11};
    int seen;

    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    last_cyc      = 0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_ptr", dbg_rr_ptr, 0);
    check("rst_rdy", bus.req_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_busy", bus.busy, 0);
    @(posedge clk); #1;

    // Fairness: all four hold req_valid; grants 0,1,2,3,0 every 9 cycles.
    for (int i = 0; i < NREQ; i++) set_req(i, N'(i + 1), N'(10 * (i + 1)));
    for (int op = 0; op < 5; op++) begin
      wait_grant("rr", g);
      check("rr_order", g, order[op]);
      if (op > 0) check("rr_interval", cyc - last_cyc, LAT + 2);
      last_cyc = cyc;
      exp_q.push_back({IDW'(order[op]), fsum[op]});
      @(posedge clk); #1;
      n = 1;
      wait_rsp("rr", n);
      take_rsp("rr");
    end
    for (int i = 0; i < NREQ; i++) clr_req(i);

    // Single request and wrap-around sums.
    issue(0, 64'd5, 64'd7, 64'd12, "single");
    issue(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, "wrap1");
    issue(2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'd0, "wrap2");

    // Pointer skip: bring rr_ptr to 2, then only req 0 and req 3 valid.
    issue(1, 64'd3, 64'd4, 64'd7, "ptr_setup");
    @(negedge clk);
    check("ptr_is2", dbg_rr_ptr, 2);
    @(posedge clk); #1;
    set_req(0, 64'd100, 64'd200);
    set_req(3, 64'd1000, 64'd2000);
    wait_grant("skip3", g);
    check("skip_first", g, 3);
    exp_q.push_back({2'd3, 64'd3000});
    @(posedge clk); #1;
    clr_req(3);
    check("skip_ptr0", dbg_rr_ptr, 0);
    n = 1;
    wait_rsp("skip3", n);
    take_rsp("skip3");
    wait_grant("skip0", g);
    check("skip_second", g, 0);
    exp_q.push_back({2'd0, 64'd300});
    @(posedge clk); #1;
    clr_req(0);
    n = 1;
    wait_rsp("skip0", n);
    take_rsp("skip0");

    // Backpressure: response held 10 cycles while req 0 waits.
    bus.rsp_ready = 1'b0;
    set_req(3, 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111);
    wait_grant("bp", g);
    check("bp_gnt", g, 3);
    exp_q.push_back({2'd3, 64'h1234_5678_9ABC_DF00});
    @(posedge clk); #1;
    clr_req(3);
    set_req(0, 64'd50, 64'd60);
    n = 1;
    wait_rsp("bp", n);
    check("bp_lat", n, LAT + 1);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_data", bus.rsp_data, 64'h1234_5678_9ABC_DF00);
      check("bp_id", bus.rsp_id, 3);
      check("bp_rdy", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    take_rsp("bp");
    @(negedge clk);
    check("bp_idle", dbg_state, IDLE);
    check("bp_rsp_drop", bus.rsp_valid, 0);
    check("bp_next_gnt", bus.req_ready, 4'b0001);
    exp_q.push_back({2'd0, 64'd110});
    @(posedge clk); #1;
    clr_req(0);
    n = 1;
    wait_rsp("bp_next", n);
    take_rsp("bp_next");

    // Reset in the third RUN cycle aborts the operation.
    set_req(2, 64'd10, 64'd20);
    wait_grant("abort", g);
    check("abort_gnt", g, 2);
    @(posedge clk); #1;
    clr_req(2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort_in_run", dbg_state, RUN);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_rsp_valid", bus.rsp_valid, 0);
    check("abort_state", dbg_state, IDLE);
    check("abort_ptr", dbg_rr_ptr, 0);
    check("abort_busy", bus.busy, 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (bus.rsp_valid) seen++;
    end
    check("abort_no_rsp", seen, 0);
    @(posedge clk); #1;
    issue(1, 64'd40, 64'd2, 64'd42, "after_abort");

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
